// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
package instr_mem_pkg;

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Default "add" no-op returned on reset, flush and out-of-range fetches.
  localparam logic [7:0] NOP_WORD_DFLT = 8'h00;

  // Full-width range check: addresses at or above depth are rejected, never aliased.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/instr_mem_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module instr_mem_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [IDXW-1:0] waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic            re_i,
  input  logic [IDXW-1:0] raddr_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // NOTE: no reset on the array or read register, so the tools can map this onto block RAM;
  // a loaded program therefore survives rst_n.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/instr_mem_ld.sv
// Loadable instruction memory: LOAD/RUN control, range checks and fetch hold/fault registers
// around a block-RAM style array.
module instr_mem_ld
  import instr_mem_pkg::*;
#(
  parameter int             IW       = 8,
  parameter int             AW       = 8,
  parameter int             DEPTH    = 16,
  parameter logic [IW-1:0]  NOP_WORD = IW'(NOP_WORD_DFLT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic          load_done,
  input  logic          fetch_req,
  input  logic [AW-1:0] pc,
  input  logic          stall,
  output logic [IW-1:0] instruction,
  output logic          instr_valid,
  output logic          addr_fault,
  output logic          load_err,
  output logic          busy
);

  localparam int IDXW = $clog2(DEPTH);

  state_e        state_q, state_d;
  logic          use_ram_q, use_ram_d;
  logic          valid_q, valid_d;
  logic          fault_q, fault_d;
  logic          err_q, err_d;
  logic          ram_we, ram_re;
  logic          load_ok, pc_ok;
  logic [IW-1:0] ram_rdata;

  assign load_ok = in_range(32'(load_addr), DEPTH);
  assign pc_ok   = in_range(32'(pc), DEPTH);

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    use_ram_d = use_ram_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    err_d     = err_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (load_we) begin
          if (load_ok) ram_we = 1'b1;
          else         err_d  = 1'b1;
        end
        if (load_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (load_start) begin
          state_d   = ST_LOAD;
          use_ram_d = 1'b0;
          valid_d   = 1'b0;
          fault_d   = 1'b0;
          err_d     = 1'b0;
        end else if (!stall) begin
          if (fetch_req) begin
            valid_d   = 1'b1;
            ram_re    = pc_ok;
            use_ram_d = pc_ok;
            fault_d   = !pc_ok;
          end else begin
            valid_d = 1'b0;
            fault_d = 1'b0;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      use_ram_q <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      use_ram_q <= use_ram_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      err_q     <= err_d;
    end
  end

  // The RAM read register only advances on accepted in-range fetches, so it doubles as the
  // instruction hold register; use_ram_q selects it over the no-op.
  instr_mem_ram #(
    .DW   (IW),
    .DEPTH(DEPTH),
    .IDXW (IDXW)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we & rst_n),
    .waddr_i(load_addr[IDXW-1:0]),
    .wdata_i(load_data),
    .re_i   (ram_re),
    .raddr_i(pc[IDXW-1:0]),
    .rdata_o(ram_rdata)
  );

  assign instruction = use_ram_q ? ram_rdata : NOP_WORD;
  assign instr_valid = valid_q;
  assign addr_fault  = fault_q;
  assign load_err    = err_q;
  assign busy        = (state_q == ST_LOAD);

endmodule
